sipo_word_collector: RTL and testbench

Serial-to-word collector that sits directly downstream of the 4-bit universal shift register and consumes its serial output stream (`sr_out` or `sl_out`). It packs qualified serial bits into W-bit words, MSB-first or LSB-first, and buffers completed words in a DEPTH-entry FIFO. The FIFO is drained through a valid/ready handshake. Overflow is detected, the offending word is dropped, and a sticky flag records the event.

---
 rtl/sipo_word_collector_if.sv | 29 ++
 rtl/sipo_word_collector.sv | 88 ++++++++
 tb/tb_sipo_word_collector.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sipo_word_collector_if.sv
// rtl/sipo_word_collector_if.sv - serial-bit and word handshake bundle for sipo_word_collector
interface sipo_word_collector_if #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH + 1);

    logic          bit_in;
    logic          bit_vld;
    logic          dir;
    logic          flush;
    logic          word_rdy;
    logic [W-1:0]  word_out;
    logic          word_vld;
    logic          full;
    logic [LW-1:0] level;
    logic          busy;
    logic          ovf;

    modport master (
        output bit_in, bit_vld, dir, flush, word_rdy,
        input  word_out, word_vld, full, level, busy, ovf
    );

    modport slave (
        input  bit_in, bit_vld, dir, flush, word_rdy,
        output word_out, word_vld, full, level, busy, ovf
    );
endinterface

// File: rtl/sipo_word_collector.sv
// rtl/sipo_word_collector.sv - packs serial bits into W-bit words and buffers them in a DEPTH-entry FIFO
module sipo_word_collector #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_word_collector_if.slave bus
);
    localparam int CW = $clog2(W);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  acc;
    logic [W-1:0]  next_word;
    logic [CW-1:0] bit_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          ovf;
    logic [W-1:0]  mem [DEPTH];

    logic complete;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic ovf_set;

    always_comb begin
        next_word = bus.dir ? {bus.bit_in, acc[W-1:1]} : {acc[W-2:0], bus.bit_in};
        empty     = (level == '0);
        full      = (level == LW'(DEPTH));
        complete  = bus.bit_vld && (bit_cnt == CW'(W - 1));
        pop       = !bus.flush && !empty && bus.word_rdy;
        // A pop on the same edge frees the slot, so a full FIFO can still accept
        push      = !bus.flush && complete && (!full || pop);
        ovf_set   = !bus.flush && complete && full && !pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            bit_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf     <= 1'b0;
        end else if (bus.flush) begin
            acc     <= '0;
            bit_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf     <= 1'b0;
        end else begin
            if (bus.bit_vld) begin
                if (complete) begin
                    acc     <= '0;
                    bit_cnt <= '0;
                end else begin
                    acc     <= next_word;
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (ovf_set) ovf <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= next_word;
    end

    assign bus.word_out = empty ? '0 : mem[rd_ptr];
    assign bus.word_vld = !empty;
    assign bus.full     = full;
    assign bus.level    = level;
    assign bus.busy     = (bit_cnt != '0);
    assign bus.ovf      = ovf;
endmodule

// File: tb/tb_sipo_word_collector.sv
// tb/tb_sipo_word_collector.sv - directed self-checking bench for sipo_word_collector
module tb_sipo_word_collector;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    sipo_word_collector_if #(.W(4), .DEPTH(4)) ifc ();

    sipo_word_collector #(.W(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        ifc.bit_in   = b;
        ifc.bit_vld  = 1'b1;
        ifc.word_rdy = rdy;
        step();
        ifc.bit_vld  = 1'b0;
        ifc.word_rdy = 1'b0;
    endtask

    task automatic push_word(input logic [3:0] w, input logic last_rdy);
        for (int i = 3; i >= 0; i--) send_bit(w[i], (i == 0) ? last_rdy : 1'b0);
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] exp);
        chk({tag, "_data"}, ifc.word_out, exp);
        chk({tag, "_vld"}, ifc.word_vld, 1'b1);
        ifc.word_rdy = 1'b1;
        step();
        ifc.word_rdy = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        chk({tag, "_vld"}, ifc.word_vld, 1'b0);
        chk({tag, "_level"}, ifc.level, 3'd0);
        chk({tag, "_busy"}, ifc.busy, 1'b0);
        chk({tag, "_ovf"}, ifc.ovf, 1'b0);
        chk({tag, "_out"}, ifc.word_out, 4'h0);
        chk({tag, "_full"}, ifc.full, 1'b0);
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        rst          = 1'b0;
        ifc.bit_in   = 1'b0;
        ifc.bit_vld  = 1'b0;
        ifc.dir      = 1'b0;
        ifc.flush    = 1'b0;
        ifc.word_rdy = 1'b0;
        step();
        check_clear("reset");
        rst = 1'b1;
        step();

        // MSB-first: 1,0,1,1 -> 4'b1011
        ifc.dir = 1'b0;
        send_bit(1'b1, 1'b0);
        chk("msb_busy_mid", ifc.busy, 1'b1);
        chk("msb_vld_mid", ifc.word_vld, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("msb_level", ifc.level, 3'd1);
        chk("msb_busy", ifc.busy, 1'b0);
        pop_expect("msb", 4'b1011);
        chk("msb_empty_after_pop", ifc.word_vld, 1'b0);

        // LSB-first: 1,0,1,1 -> 4'b1101
        ifc.dir = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        pop_expect("lsb", 4'b1101);
        ifc.dir = 1'b0;

        // Push with rdy high into an empty FIFO: pop ignored, push taken
        push_word(4'h9, 1'b1);
        chk("empty_collide_level", ifc.level, 3'd1);
        pop_expect("empty_collide", 4'h9);

        // Overflow drop
        push_word(4'h1, 1'b0);
        push_word(4'h2, 1'b0);
        push_word(4'h3, 1'b0);
        push_word(4'h4, 1'b0);
        chk("ovf_full", ifc.full, 1'b1);
        chk("ovf_level4", ifc.level, 3'd4);
        chk("ovf_pre", ifc.ovf, 1'b0);
        push_word(4'h5, 1'b0);
        chk("ovf_set", ifc.ovf, 1'b1);
        chk("ovf_level_kept", ifc.level, 3'd4);
        chk("ovf_hold_data", ifc.word_out, 4'h1);
        pop_expect("ovf_pop1", 4'h1);
        pop_expect("ovf_pop2", 4'h2);
        pop_expect("ovf_pop3", 4'h3);
        pop_expect("ovf_pop4", 4'h4);
        chk("ovf_drained", ifc.word_vld, 1'b0);
        chk("ovf_sticky", ifc.ovf, 1'b1);

        // Flush clears ovf
        ifc.flush = 1'b1;
        step();
        ifc.flush = 1'b0;
        check_clear("flush_ovf");

        // Push/pop collision when full
        push_word(4'h1, 1'b0);
        push_word(4'h2, 1'b0);
        push_word(4'h3, 1'b0);
        push_word(4'h4, 1'b0);
        chk("coll_head", ifc.word_out, 4'h1);
        push_word(4'h5, 1'b1);
        chk("coll_level", ifc.level, 3'd4);
        chk("coll_ovf", ifc.ovf, 1'b0);
        chk("coll_full", ifc.full, 1'b1);
        pop_expect("coll_pop2", 4'h2);
        pop_expect("coll_pop3", 4'h3);
        pop_expect("coll_pop4", 4'h4);
        pop_expect("coll_pop5", 4'h5);
        chk("coll_drained", ifc.word_vld, 1'b0);

        // Flush with a bit on the same edge, ovf and partial word pending
        for (int i = 0; i < 5; i++) push_word(4'(i + 1), 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("fl_pre_ovf", ifc.ovf, 1'b1);
        ifc.flush   = 1'b1;
        ifc.bit_in  = 1'b1;
        ifc.bit_vld = 1'b1;
        ifc.word_rdy = 1'b1;
        step();
        ifc.flush    = 1'b0;
        ifc.bit_vld  = 1'b0;
        ifc.word_rdy = 1'b0;
        check_clear("flush");
        push_word(4'b0110, 1'b0);
        chk("flush_level", ifc.level, 3'd1);
        pop_expect("flush_word", 4'b0110);

        // Asynchronous reset mid-stream: 2 words and 2 bits pending
        push_word(4'hA, 1'b0);
        push_word(4'hB, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("rst_pre_level", ifc.level, 3'd2);
        chk("rst_pre_busy", ifc.busy, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check_clear("async_rst");
        rst = 1'b1;
        push_word(4'b0110, 1'b0);
        chk("rst_level", ifc.level, 3'd1);
        pop_expect("rst_word", 4'b0110);
        chk("rst_drained", ifc.word_vld, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
